// File: rtl/multicycle_control.sv
// Moore-style multicycle sequencer stepping the shared ALU and memory port through each instruction.
// Define JUMP_EN to build the JUMP state (opcode 000100); otherwise that opcode is treated as illegal.
module multicycle_control (
  input  logic       clk,
  input  logic       nReset,
  input  logic [5:0] opCode,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memToReg,
  output logic       regWrite,
  output logic       regDst,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSource,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADDR  = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECUTE  = 4'd6;
  localparam logic [3:0] RWB      = 4'd7;
  localparam logic [3:0] BRANCH   = 4'd8;
`ifdef JUMP_EN
  localparam logic [3:0] JUMP     = 4'd9;
`endif
  localparam logic [3:0] ILLEGAL  = 4'd15;

  logic [3:0] state_q, state_d;
  logic       illegal_q, illegal_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (memReady) state_d = DECODE;
      DECODE: begin
        case (opCode)
          6'b000000: state_d = EXECUTE;
          6'b000001: state_d = MEMADDR;
          6'b000010: state_d = MEMADDR;
          6'b000011: state_d = BRANCH;
`ifdef JUMP_EN
          6'b000100: state_d = JUMP;
`endif
          default:   state_d = ILLEGAL;
        endcase
      end
      MEMADDR:  state_d = (opCode == 6'b000001) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (memReady) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (memReady) state_d = FETCH;
      EXECUTE:  state_d = RWB;
      RWB:      state_d = FETCH;
      BRANCH:   state_d = FETCH;
`ifdef JUMP_EN
      JUMP:     state_d = FETCH;
`endif
      ILLEGAL:  state_d = ILLEGAL;
      default:  state_d = FETCH;
    endcase
  end

  assign illegal_d = illegal_q | (state_d == ILLEGAL);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Decoded from the state register alone; only FETCH's IR/PC loads look at memReady.
  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    memToReg    = 1'b0;
    regWrite    = 1'b0;
    regDst      = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    aluOp       = 2'b00;
    pcSource    = 2'b00;
    if (nReset) begin
      case (state_q)
        FETCH: begin
          memRead = 1'b1;
          aluSrcB = 2'b01;
          irWrite = memReady;
          pcWrite = memReady;
        end
        DECODE:  aluSrcB = 2'b11;
        MEMADDR: begin
          aluSrcA = 1'b1;
          aluSrcB = 2'b10;
        end
        MEMREAD: begin
          memRead = 1'b1;
          iorD    = 1'b1;
        end
        MEMWB: begin
          regWrite = 1'b1;
          memToReg = 1'b1;
        end
        MEMWRITE: begin
          memWrite = 1'b1;
          iorD     = 1'b1;
        end
        EXECUTE: begin
          aluSrcA = 1'b1;
          aluOp   = 2'b10;
        end
        RWB: begin
          regWrite = 1'b1;
          regDst   = 1'b1;
        end
        BRANCH: begin
          aluSrcA     = 1'b1;
          aluOp       = 2'b01;
          pcWriteCond = 1'b1;
          pcSource    = 2'b01;
        end
`ifdef JUMP_EN
        JUMP: begin
          pcWrite  = 1'b1;
          pcSource = 2'b10;
        end
`endif
        default: ;
      endcase
    end
  end

  assign illegal = illegal_q & nReset;
  assign state   = nReset ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: a per-instruction model expands opcode and wait counts into the expected
// state trace, and a state-to-control table gives the expected outputs for every cycle.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       nReset;
  logic [5:0] opCode;
  logic       memReady;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       memToReg, regWrite, regDst, aluSrcA, illegal;
  logic [1:0] aluSrcB, aluOp, pcSource;
  logic [3:0] state;
  logic [16:0] actVec;

  int passCount = 0;
  int checkCount = 0;

`ifdef JUMP_EN
  localparam bit JumpEn = 1'b1;
`else
  localparam bit JumpEn = 1'b0;
`endif

  int          expSt[$];
  bit          expRdy[$];
  logic [5:0]  expOp[$];

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .nReset(nReset), .opCode(opCode), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .memToReg(memToReg), .regWrite(regWrite), .regDst(regDst),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .pcSource(pcSource), .illegal(illegal), .state(state)
  );

  assign actVec = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
                   regWrite, regDst, aluSrcA, aluSrcB, aluOp, pcSource, illegal};

  // Control table: what each step of an instruction must drive.
  function automatic logic [16:0] expOut(input int st, input bit rdy);
    logic pcW, pcWC, ioD, mRd, mWr, irW, m2r, rW, rD, aA, ill;
    logic [1:0] aB, aO, pS;
    {pcW, pcWC, ioD, mRd, mWr, irW, m2r, rW, rD, aA, ill} = '0;
    aB = 2'd0; aO = 2'd0; pS = 2'd0;
    case (st)
      0:  begin mRd = 1; aB = 2'd1; irW = rdy; pcW = rdy; end
      1:  aB = 2'd3;
      2:  begin aA = 1; aB = 2'd2; end
      3:  begin mRd = 1; ioD = 1; end
      4:  begin rW = 1; m2r = 1; end
      5:  begin mWr = 1; ioD = 1; end
      6:  begin aA = 1; aO = 2'd2; end
      7:  begin rW = 1; rD = 1; end
      8:  begin aA = 1; aO = 2'd1; pcWC = 1; pS = 2'd1; end
      9:  begin pcW = 1; pS = 2'd2; end
      15: ill = 1;
      default: ;
    endcase
    return {pcW, pcWC, ioD, mRd, mWr, irW, m2r, rW, rD, aA, aB, aO, pS, ill};
  endfunction

  function automatic bit randBit();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic push(input int st, input bit rdy, input logic [5:0] op);
    expSt.push_back(st);
    expRdy.push_back(rdy);
    expOp.push_back(op);
  endtask

  // Expands one instruction into its cycle trace from the ISA rules.
  task automatic buildInstr(input logic [5:0] op, input int fetchWaits, input int memWaits);
    for (int i = 0; i < fetchWaits; i++) push(0, 1'b0, op);
    push(0, 1'b1, op);
    push(1, randBit(), op);
    if (op == 6'd0) begin
      push(6, randBit(), op);
      push(7, randBit(), op);
    end else if (op == 6'd1) begin
      push(2, randBit(), op);
      for (int i = 0; i < memWaits; i++) push(3, 1'b0, op);
      push(3, 1'b1, op);
      push(4, randBit(), op);
    end else if (op == 6'd2) begin
      push(2, randBit(), op);
      for (int i = 0; i < memWaits; i++) push(5, 1'b0, op);
      push(5, 1'b1, op);
    end else if (op == 6'd3) begin
      push(8, randBit(), op);
    end else if (op == 6'd4 && JumpEn) begin
      push(9, randBit(), op);
    end else begin
      push(15, randBit(), op);
    end
  endtask

  task automatic driveCycle(output int eSt, output logic [16:0] eVec);
    bit r;
    logic [5:0] op;
    eSt = expSt.pop_front();
    r   = expRdy.pop_front();
    op  = expOp.pop_front();
    @(negedge clk);
    memReady = r;
    opCode   = (eSt == 0) ? 6'($urandom) : op;
    #1;
    eVec = expOut(eSt, r);
  endtask

  task automatic test_reset();
    int eSt;
    logic [16:0] eVec;
    nReset = 1'b0; memReady = 1'b1; opCode = 6'd0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checkCount++;
    if (actVec !== 17'd0 || state !== 4'd0)
      $display("[TB] FAIL reset_hold: got ctrl=%h state=%0d want ctrl=0 state=0", actVec, state);
    else passCount++;
    #1 nReset = 1'b1; #1;
    checkCount++;
    if (actVec !== expOut(0, 1'b1) || state !== 4'd0)
      $display("[TB] FAIL reset_release_fetch: got ctrl=%h state=%0d want ctrl=%h state=0",
               actVec, state, expOut(0, 1'b1));
    else passCount++;
    push(1, randBit(), 6'd0);
    push(6, randBit(), 6'd0);
    while (expSt.size() > 0) begin
      driveCycle(eSt, eVec);
      checkCount++;
      if (state !== 4'(eSt) || actVec !== eVec)
        $display("[TB] FAIL reset_seq: got state=%0d ctrl=%h want state=%0d ctrl=%h", state, actVec, eSt, eVec);
      else passCount++;
    end
    #1 nReset = 1'b0; #1;
    checkCount++;
    if (actVec !== 17'd0 || state !== 4'd0)
      $display("[TB] FAIL reset_mid_execute: got ctrl=%h state=%0d want ctrl=0 state=0", actVec, state);
    else passCount++;
    @(posedge clk); #1;
    nReset = 1'b1; memReady = 1'b0;
  endtask

  task automatic test_rtype();
    int eSt;
    logic [16:0] eVec;
    buildInstr(6'd0, 0, 0);
    while (expSt.size() > 0) begin
      driveCycle(eSt, eVec);
      checkCount++;
      if (state !== 4'(eSt)) $display("[TB] FAIL rtype_state: got %0d want %0d", state, eSt);
      else passCount++;
      checkCount++;
      if (actVec !== eVec) $display("[TB] FAIL rtype_ctrl: got %h want %h (state %0d)", actVec, eVec, eSt);
      else passCount++;
    end
  endtask

  task automatic test_lw_waits();
    int eSt;
    logic [16:0] eVec;
    buildInstr(6'd1, 0, 2);
    while (expSt.size() > 0) begin
      driveCycle(eSt, eVec);
      checkCount++;
      if (state !== 4'(eSt)) $display("[TB] FAIL lw_state: got %0d want %0d", state, eSt);
      else passCount++;
      checkCount++;
      if (actVec !== eVec) $display("[TB] FAIL lw_ctrl: got %h want %h (state %0d)", actVec, eVec, eSt);
      else passCount++;
    end
  endtask

  task automatic test_beq();
    int eSt;
    logic [16:0] eVec;
    buildInstr(6'd3, 1, 0);
    while (expSt.size() > 0) begin
      driveCycle(eSt, eVec);
      checkCount++;
      if (state !== 4'(eSt) || actVec !== eVec)
        $display("[TB] FAIL beq: got state=%0d ctrl=%h want state=%0d ctrl=%h", state, actVec, eSt, eVec);
      else passCount++;
    end
  endtask

  task automatic test_jump();
    int eSt;
    logic [16:0] eVec;
    buildInstr(6'd4, 0, 0);
    while (expSt.size() > 0) begin
      driveCycle(eSt, eVec);
      checkCount++;
      if (state !== 4'(eSt) || actVec !== eVec)
        $display("[TB] FAIL jump: got state=%0d ctrl=%h want state=%0d ctrl=%h", state, actVec, eSt, eVec);
      else passCount++;
    end
    // Without the jump state the bench has stranded the DUT in ILLEGAL; recover.
    if (!JumpEn) begin
      @(negedge clk); nReset = 1'b0;
      @(posedge clk); #1; nReset = 1'b1; memReady = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int eSt;
    logic [16:0] eVec;
    logic [5:0] op;
    for (int n = 0; n < 24; n++) begin
      op = 6'($urandom_range(0, JumpEn ? 4 : 3));
      buildInstr(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end
    while (expSt.size() > 0) begin
      driveCycle(eSt, eVec);
      checkCount++;
      if (state !== 4'(eSt) || actVec !== eVec)
        $display("[TB] FAIL back_to_back: got state=%0d ctrl=%h want state=%0d ctrl=%h", state, actVec, eSt, eVec);
      else passCount++;
    end
  endtask

  task automatic test_illegal();
    int eSt;
    logic [16:0] eVec;
    buildInstr(6'h3F, 0, 0);
    for (int i = 0; i < 12; i++) push(15, randBit(), 6'($urandom));
    while (expSt.size() > 0) begin
      driveCycle(eSt, eVec);
      checkCount++;
      if (state !== 4'(eSt) || actVec !== eVec)
        $display("[TB] FAIL illegal_hold: got state=%0d ctrl=%h want state=%0d ctrl=%h", state, actVec, eSt, eVec);
      else passCount++;
    end
    #1 nReset = 1'b0; #1;
    checkCount++;
    if (illegal !== 1'b0 || state !== 4'd0)
      $display("[TB] FAIL illegal_clear: got illegal=%b state=%0d want illegal=0 state=0", illegal, state);
    else passCount++;
    @(posedge clk); #1;
    nReset = 1'b1; memReady = 1'b0;
    buildInstr(6'd3, 0, 0);
    while (expSt.size() > 0) begin
      driveCycle(eSt, eVec);
      checkCount++;
      if (state !== 4'(eSt) || actVec !== eVec)
        $display("[TB] FAIL illegal_recover: got state=%0d ctrl=%h want state=%0d ctrl=%h", state, actVec, eSt, eVec);
      else passCount++;
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_waits();
    test_beq();
    test_jump();
    test_back_to_back();
    test_illegal();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle sequencer for the microprocessor datapath. Replaces single-cycle opcode decoding with a Moore-style FSM that steps one shared ALU and one shared memory port through fetch, decode, execute, memory and write-back cycles. It stretches memory cycles on a ready handshake and raises a sticky flag on unknown opcodes. It sits between the instruction register's opcode field and the datapath mux and enable inputs.

## Interface
- No parameters.
- clk  input  1  system clock; all state changes on the rising edge.
- nReset  input  1  asynchronous, active-low reset.
- opCode  input  6  instruction register bits [31:26]; valid from DECODE onward.
- memReady  input  1  memory port completes the current access this cycle.
- pcWrite, pcWriteCond  output  1 each  unconditional PC load / PC load if ALU zero.
- iorD  output  1  memory address source: 0 = PC, 1 = ALUOut.
- memRead, memWrite  output  1 each  memory port strobes.
- irWrite  output  1  instruction register load.
- memToReg, regWrite, regDst  output  1 each  write-back controls.
- aluSrcA  output  1  ALU A source: 0 = PC, 1 = register A.
- aluSrcB  output  2  ALU B source: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted immediate.
- aluOp  output  2  00 = add, 01 = subtract, 10 = funct field.
- pcSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal  output  1  sticky unknown-opcode flag.
- state  output  4  current state, for debug.

## Operation
- States and encodings: FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, RWB=7, BRANCH=8, JUMP=9, ILLEGAL=15. Unused encodings go to FETCH.
- Outputs not listed for a state are 0.
- **FETCH:** memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00.
  - irWrite and pcWrite equal memReady.
  - Stay in FETCH while memReady=0; go to DECODE when memReady=1.
- **DECODE:** aluSrcA=0, aluSrcB=11, aluOp=00 (branch target into ALUOut). Next state by opCode:
  - 000000 → EXECUTE
  - 000001 → MEMADDR
  - 000010 → MEMADDR
  - 000011 → BRANCH
  - 000100 → JUMP (only with JUMP_EN)
  - anything else → ILLEGAL
- **MEMADDR:** aluSrcA=1, aluSrcB=10, aluOp=00. Opcode 000001 → MEMREAD, otherwise → MEMWRITE.
- **MEMREAD:** memRead=1, iorD=1. Hold until memReady=1, then go to MEMWB.
- **MEMWB:** regWrite=1, memToReg=1, regDst=0 → FETCH.
- **MEMWRITE:** memWrite=1, iorD=1. Hold until memReady=1, then go to FETCH.
- **EXECUTE:** aluSrcA=1, aluSrcB=00, aluOp=10 → RWB.
- **RWB:** regWrite=1, memToReg=0, regDst=1 → FETCH.
- **BRANCH:** aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01 → FETCH.
- **JUMP:** pcWrite=1, pcSource=10 → FETCH.
- **ILLEGAL:** all enables 0, illegal=1. Terminal state; only nReset leaves it.
- Memory handshake rules:
  - memRead/memWrite and iorD stay constant from the first cycle of an access until the cycle memReady is sampled high.
  - memReady is ignored in every state except FETCH, MEMREAD and MEMWRITE.

## Timing
- Cycles per instruction with zero wait states: R-type 4, LW 5, SW 4, BEQ 3, JUMP 3. Each memReady=0 cycle during an access adds one cycle.
- Outputs depend on the state register only, except irWrite and pcWrite in FETCH, which are combinational on memReady. No other input-to-output paths.
- opCode is sampled only at the DECODE and MEMADDR clock edges.
- Reset:
  - nReset low asynchronously forces state=FETCH and illegal=0.
  - While nReset is low, every output is forced to 0.
  - The first edge after release is a normal FETCH cycle.
- Reset mid-operation: abandons the instruction immediately; no partial write-back. A pending memRead/memWrite drops at once.

## Configuration
- JUMP_EN defined: opcode 000100 decodes to JUMP.
- JUMP_EN undefined: the JUMP state is not built; 000100 goes to ILLEGAL like any unknown opcode.

## Test plan
- Reset: nReset low mid-EXECUTE → all outputs 0 and state=0 immediately. After release with memReady=1: FETCH outputs, with memRead=1, aluSrcB=01 and irWrite=1.
- R-type: opCode=000000, memReady=1 → states 0,1,6,7,0. regWrite=1 and regDst=1 only in state 7.
- LW with waits: opCode=000001, memReady low for 2 cycles in MEMREAD → states 0,1,2,3,3,3,4,0. iorD=1 and memRead=1 held all three MEMREAD cycles.
- BEQ: opCode=000011 → states 0,1,8,0. pcWriteCond=1, aluOp=01, pcSource=01 in state 8.
- Illegal: opCode=111111 → state 15 and illegal=1. Both held for 10+ cycles, no enables asserted, cleared only by nReset.
- JUMP with JUMP_EN: opCode=000100 → states 0,1,9,0 with pcWrite=1 and pcSource=10. Without JUMP_EN the same stimulus reaches state 15.
